// File: rtl/regset_pkg.sv
// rtl/regset_pkg.sv - shared widths, address map and reset value for regset
package regset_pkg;

    localparam int          ADDR_W        = 10;
    localparam int          DATA_W        = 32;
    localparam logic [9:0]  DATA0_ADDR    = 10'h000;
    localparam logic [9:0]  DATA0_SR_ADDR = 10'h004;
    localparam logic [31:0] DATA0_RST     = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DATA0,
        SEL_DATA0_SR
    } reg_sel_e;

endpackage

// File: rtl/regset_rw_reg.sv
// rtl/regset_rw_reg.sv - write-enabled register with async active-low reset
module regset_rw_reg #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regset.sv
// rtl/regset.sv - DATA0 read/write register with read-only DATA0_SR mirror
module regset
    import regset_pkg::*;
#(
    parameter int                ADDR_W    = regset_pkg::ADDR_W,
    parameter int                DATA_W    = regset_pkg::DATA_W,
    parameter logic [DATA_W-1:0] DATA0_RST = DATA_W'(regset_pkg::DATA0_RST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    reg_sel_e          sel;
    logic [DATA_W-1:0] data0;
    logic              data0_we;

    // Full-width compare so upper address bits never alias onto a register.
    always_comb begin
        sel = SEL_NONE;
        if (addr == ADDR_W'(DATA0_ADDR)) begin
            sel = SEL_DATA0;
        end else if (addr == ADDR_W'(DATA0_SR_ADDR)) begin
            sel = SEL_DATA0_SR;
        end
    end

    assign data0_we = wr_en && (sel == SEL_DATA0);

    regset_rw_reg #(
        .DATA_W  (DATA_W),
        .RST_VAL (DATA0_RST)
    ) u_data0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (data0_we),
        .d     (wdata),
        .q     (data0)
    );

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (sel)
                SEL_DATA0, SEL_DATA0_SR: rdata = data0;
                default:                 rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_regset.sv
// tb/tb_regset.sv - vector and scoreboard bench for regset
module tb_regset;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int checks;
    int errors;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_exp[$];
    string       sb_name[$];

    regset dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic wr, input logic rd, input logic [9:0] a,
                           input logic [31:0] wd, input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [9:0] a,
                         input logic [31:0] wd);
        wr_en = wr; rd_en = rd; addr = a; wdata = wd;
    endtask

    task automatic expect_rd(input string nm, input logic [31:0] e);
        sb_exp.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic sample_rd();
        logic [31:0] e;
        string       nm;
        #1;
        if (sb_exp.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow actual=%h", rdata);
            return;
        end
        e  = sb_exp.pop_front();
        nm = sb_name.pop_front();
        checks++;
        if (rdata !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, rdata, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 10'h000, 32'h0);

        //      wr    rd    addr     wdata          expected rdata (pre-edge)
        add_vec(1'b0, 1'b1, 10'h000, 32'h0,         32'h0000_0000);
        add_vec(1'b0, 1'b1, 10'h004, 32'h0,         32'h0000_0000);
        add_vec(1'b1, 1'b0, 10'h000, 32'hAAAA_5555, 32'h0000_0000);
        add_vec(1'b0, 1'b1, 10'h000, 32'h0,         32'hAAAA_5555);
        add_vec(1'b0, 1'b1, 10'h004, 32'h0,         32'hAAAA_5555);
        add_vec(1'b1, 1'b1, 10'h004, 32'hFFFF_FFFF, 32'hAAAA_5555);
        add_vec(1'b0, 1'b1, 10'h004, 32'h0,         32'hAAAA_5555);
        add_vec(1'b0, 1'b1, 10'h000, 32'h0,         32'hAAAA_5555);
        add_vec(1'b0, 1'b1, 10'h008, 32'h0,         32'h0000_0000);
        add_vec(1'b0, 1'b1, 10'h100, 32'h0,         32'h0000_0000);
        add_vec(1'b0, 1'b1, 10'h3FC, 32'h0,         32'h0000_0000);
        add_vec(1'b0, 1'b0, 10'h000, 32'h0,         32'h0000_0000);
        add_vec(1'b1, 1'b1, 10'h000, 32'h1111_2222, 32'hAAAA_5555);
        add_vec(1'b1, 1'b1, 10'h000, 32'h5555_6666, 32'h1111_2222);
        add_vec(1'b0, 1'b1, 10'h000, 32'h0,         32'h5555_6666);
        add_vec(1'b0, 1'b1, 10'h004, 32'h0,         32'h5555_6666);
        add_vec(1'b1, 1'b0, 10'h000, 32'h9999_AAAA, 32'h0000_0000);
        add_vec(1'b0, 1'b1, 10'h000, 32'h0,         32'h9999_AAAA);
        add_vec(1'b1, 1'b0, 10'h004, 32'h1234_5678, 32'h0000_0000);
        add_vec(1'b0, 1'b1, 10'h004, 32'h0,         32'h9999_AAAA);
        add_vec(1'b1, 1'b0, 10'h008, 32'hDEAD_BEEF, 32'h0000_0000);
        add_vec(1'b1, 1'b0, 10'h100, 32'hDEAD_BEEF, 32'h0000_0000);
        add_vec(1'b0, 1'b1, 10'h000, 32'h0,         32'h9999_AAAA);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            expect_rd($sformatf("vec%0d_a%03h", i, vecs[i].addr), vecs[i].exp);
            sample_rd();
        end

        // Async reset asserted between edges must clear DATA0 before any clk edge.
        @(negedge clk);
        drive(1'b0, 1'b1, 10'h000, 32'h0);
        expect_rd("pre_async_reset", 32'h9999_AAAA);
        sample_rd();
        rst_n = 1'b0;
        expect_rd("async_reset_immediate", 32'h0000_0000);
        sample_rd();
        expect_rd("async_reset_sr", 32'h0000_0000);
        addr = 10'h004;
        sample_rd();

        // Writes attempted while reset is held are dropped.
        drive(1'b1, 1'b1, 10'h000, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        expect_rd("write_during_reset", 32'h0000_0000);
        sample_rd();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 10'h000, 32'h0);
        expect_rd("after_reset_release", 32'h0000_0000);
        sample_rd();

        @(negedge clk);
        drive(1'b1, 1'b0, 10'h000, 32'hCAFE_F00D);
        @(negedge clk);
        drive(1'b0, 1'b1, 10'h004, 32'h0);
        expect_rd("write_after_reset", 32'hCAFE_F00D);
        sample_rd();

        if (sb_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
